// File: rtl/button_conditioner.sv
// Multi-channel input conditioner for asynchronous inputs such as call buttons, floor
// switches and door sensors. Each channel has a synchroniser, a debounce counter, and
// registered level/rise/fall outputs. Channels are fully independent.
module button_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] userinput,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameter values at elaboration time
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("button_conditioner: SYNC_STAGES must be 2 or more");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("button_conditioner: DEBOUNCE_CYCLES must be 1 or more");
  end

  // Stage 0 samples the raw inputs; the last stage is the synchronised value
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;

  logic [WIDTH-1:0]            level_q, level_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], userinput};
    end
  end

  // Debounce next state: a sample equal to the current level restarts the count
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Edge pulses derived from the next level so they align with the level transition
  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Debounce state and registered pulse outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule
